// File: rtl/otter_mmio_pkg.sv
// OTTER IOBUS address map, interrupt controller state type and shared helpers.
// Pure declarations; no logic, no latency.
package otter_mmio_pkg;

  localparam logic [31:0] SWITCHES_AD   = 32'h1100_0000;
  localparam logic [31:0] LEDS_AD       = 32'h1100_0020;
  localparam logic [31:0] SSEG_AD       = 32'h1100_0040;
  localparam logic [31:0] INTC_PEND_AD  = 32'h1100_0060;
  localparam logic [31:0] INTC_MASK_AD  = 32'h1100_0064;
  localparam logic [31:0] INTC_CAUSE_AD = 32'h1100_0068;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HOLDOFF} intc_state_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

endpackage

// File: rtl/otter_intc_edge.sv
// Per-source rising-edge detector; one-cycle pulse, same cycle as the sampled rise,
// or two cycles later behind the INTC_SYNC_EN synchronizer. No backpressure.
module otter_intc_edge (
  input  logic clk,
  input  logic rst,
  input  logic src,
  output logic pulse
);

  logic level;
  logic prev;

`ifdef INTC_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], src};
  end

  assign level = sync[1];
`else
  assign level = src;
`endif

  // prev resets high so a source already asserted at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/otter_intc.sv
// OTTER interrupt controller: pending/mask/cause MMIO and CPU_INTR handshake FSM.
// Reads combinational, INTR registered; INTC_SYNC_EN adds 2 cycles of source latency.
module otter_intc
  import otter_mmio_pkg::*;
#(
  parameter int          NUM_SRC = 8,
  parameter int          HOLDOFF = 4,
  parameter logic [31:0] BASE_AD = INTC_PEND_AD
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] SRC,
  input  logic [31:0]        IOBUS_ADDR,
  input  logic [31:0]        IOBUS_OUT,
  input  logic               IOBUS_WR,
  output logic [31:0]        RD_DATA,
  output logic               HIT,
  output logic               INTR
);

  localparam logic [31:0] PEND_AD  = BASE_AD;
  localparam logic [31:0] MASK_AD  = BASE_AD + 32'd4;
  localparam logic [31:0] CAUSE_AD = BASE_AD + 32'd8;

  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] act;
  logic [NUM_SRC-1:0] clr;
  logic               sel_pend, sel_mask, sel_cause;
  logic               ack;
  logic [31:0]        cause;
  logic [15:0]        cnt;
  intc_state_t        state;
  logic               unused_wdata;

  assign unused_wdata = &{1'b0, IOBUS_OUT[31:NUM_SRC]};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    otter_intc_edge u_edge (
      .clk   (CLK),
      .rst   (RST),
      .src   (SRC[i]),
      .pulse (edges[i])
    );
  end

  assign sel_pend  = (IOBUS_ADDR == PEND_AD);
  assign sel_mask  = (IOBUS_ADDR == MASK_AD);
  assign sel_cause = (IOBUS_ADDR == CAUSE_AD);
  assign HIT       = sel_pend | sel_mask | sel_cause;
  assign ack       = IOBUS_WR & sel_cause;

  assign clr   = (IOBUS_WR && sel_pend) ? IOBUS_OUT[NUM_SRC-1:0] : '0;
  assign act   = pend & mask;
  assign cause = {|act, 27'd0, lowest_set(16'(act))};

  // A new edge is ORed in after the clear, so it survives a same-cycle W1C.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend <= '0;
      mask <= '0;
    end else begin
      pend <= (pend & ~clr) | edges;
      if (IOBUS_WR && sel_mask) mask <= IOBUS_OUT[NUM_SRC-1:0];
    end
  end

  always_comb begin
    RD_DATA = 32'd0;
    if (sel_pend)  RD_DATA = 32'(pend);
    if (sel_mask)  RD_DATA = 32'(mask);
    if (sel_cause) RD_DATA = cause;
  end

  // Leaving HOLDOFF as the count steps down to 1 gives HOLDOFF low cycles including IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      INTR  <= 1'b0;
      cnt   <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|act) begin
            state <= ST_ACTIVE;
            INTR  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (ack || !(|act)) begin
            state <= ST_HOLDOFF;
            INTR  <= 1'b0;
            cnt   <= 16'(HOLDOFF);
          end
        end
        ST_HOLDOFF: begin
          if (cnt <= 16'd2) begin
            state <= ST_IDLE;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          INTR  <= 1'b0;
          cnt   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_intc.sv
// Directed plan steps plus randomized traffic against a rule-level model of otter_intc.
module tb_otter_intc;
  import otter_mmio_pkg::*;

  localparam int H = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  SRC;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic        HIT;
  logic        INTR;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_pend, m_mask, m_prev;
  logic       m_intr;
  int         m_block;

  otter_intc #(.NUM_SRC(8), .HOLDOFF(H), .BASE_AD(INTC_PEND_AD)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SRC        (SRC),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RD_DATA    (RD_DATA),
    .HIT        (HIT),
    .INTR       (INTR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return (a == INTC_PEND_AD) || (a == INTC_MASK_AD) || (a == INTC_CAUSE_AD);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [7:0] act;
    act  = m_pend & m_mask;
    m_rd = 32'd0;
    if (a == INTC_PEND_AD) m_rd = {24'd0, m_pend};
    if (a == INTC_MASK_AD) m_rd = {24'd0, m_mask};
    if (a == INTC_CAUSE_AD && act != 8'd0) begin
      m_rd[31] = 1'b1;
      for (int i = 7; i >= 0; i--) if (act[i]) m_rd[3:0] = 4'(i);
    end
  endfunction

  // One clock: apply inputs, advance the model by the rules, compare after the edge.
  task automatic cyc(input logic rst, input logic [7:0] src, input logic wr,
                     input logic [31:0] addr, input logic [31:0] data);
    logic [7:0] act, clr;
    logic       ackw;
    RST = rst; SRC = src; IOBUS_WR = wr; IOBUS_ADDR = addr; IOBUS_OUT = data;
    @(posedge CLK);
    act  = m_pend & m_mask;
    ackw = wr && (addr == INTC_CAUSE_AD);
    clr  = (wr && addr == INTC_PEND_AD) ? data[7:0] : 8'd0;
    if (rst) begin
      m_pend = 8'd0; m_mask = 8'd0; m_prev = 8'hFF; m_intr = 1'b0; m_block = 0;
    end else begin
      if (m_intr) begin
        if (ackw || act == 8'd0) begin
          m_intr  = 1'b0;
          m_block = H - 1;
        end
      end else if (m_block > 0) begin
        m_block--;
      end else if (act != 8'd0) begin
        m_intr = 1'b1;
      end
      m_pend = (m_pend & ~clr) | (src & ~m_prev);
      if (wr && addr == INTC_MASK_AD) m_mask = data[7:0];
      m_prev = src;
    end
    #1;
    check("intr", {31'd0, INTR}, {31'd0, m_intr});
    check("rd_data", RD_DATA, m_rd(addr));
    check("hit", {31'd0, HIT}, {31'd0, m_hit(addr)});
  endtask

  initial begin
    logic [7:0]  rs;
    logic [31:0] ra;
    m_pend = 8'd0; m_mask = 8'd0; m_prev = 8'hFF; m_intr = 1'b0; m_block = 0;

    // Reset with SRC[0] high; a source already high must not register an edge.
    cyc(1'b1, 8'h01, 1'b0, INTC_PEND_AD, 32'd0);
    cyc(1'b1, 8'h01, 1'b0, INTC_PEND_AD, 32'd0);
    check("reset_intr", {31'd0, INTR}, 32'd0);
    check("reset_pend", RD_DATA, 32'd0);
    cyc(1'b1, 8'h01, 1'b0, INTC_MASK_AD, 32'd0);
    check("reset_mask", RD_DATA, 32'd0);
    cyc(1'b0, 8'h01, 1'b1, INTC_MASK_AD, 32'hFF);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 8'h01, 1'b0, INTC_PEND_AD, 32'd0);
      check("held_src_pend", RD_DATA, 32'd0);
      check("held_src_intr", {31'd0, INTR}, 32'd0);
    end

    // Two sources, lowest enabled index reported.
    cyc(1'b0, 8'h01, 1'b1, INTC_MASK_AD, 32'h0C);
    cyc(1'b0, 8'h09, 1'b0, INTC_PEND_AD, 32'd0);
    cyc(1'b0, 8'h05, 1'b0, INTC_PEND_AD, 32'd0);
    cyc(1'b0, 8'h01, 1'b0, INTC_CAUSE_AD, 32'd0);
    check("cause_two_src", RD_DATA, 32'h8000_0002);
    check("intr_up", {31'd0, INTR}, 32'd1);
    cyc(1'b0, 8'h01, 1'b0, INTC_PEND_AD, 32'd0);
    check("pend_two_src", RD_DATA, 32'h0000_000C);

    // Acknowledge, clear bit 2, holdoff of exactly H low cycles.
    cyc(1'b0, 8'h01, 1'b1, INTC_CAUSE_AD, 32'd0);
    check("ack_low", {31'd0, INTR}, 32'd0);
    cyc(1'b0, 8'h01, 1'b1, INTC_PEND_AD, 32'h04);
    check("holdoff_low1", {31'd0, INTR}, 32'd0);
    for (int i = 0; i < H - 2; i++) begin
      cyc(1'b0, 8'h01, 1'b0, INTC_PEND_AD, 32'd0);
      check("holdoff_low2", {31'd0, INTR}, 32'd0);
    end
    cyc(1'b0, 8'h01, 1'b0, INTC_CAUSE_AD, 32'd0);
    check("holdoff_rise", {31'd0, INTR}, 32'd1);
    check("cause_after_clear", RD_DATA, 32'h8000_0003);

    // Edge and W1C on the same bit in the same cycle: set wins.
    cyc(1'b0, 8'h03, 1'b1, INTC_PEND_AD, 32'h02);
    cyc(1'b0, 8'h01, 1'b0, INTC_PEND_AD, 32'd0);
    check("set_beats_clear", RD_DATA & 32'h2, 32'h2);

    // Masking off in ACTIVE drops INTR without an acknowledge.
    cyc(1'b0, 8'h01, 1'b1, INTC_MASK_AD, 32'd0);
    cyc(1'b0, 8'h01, 1'b0, INTC_PEND_AD, 32'd0);
    check("mask_off_low", {31'd0, INTR}, 32'd0);
    check("mask_off_pend", RD_DATA, 32'h0000_000A);
    cyc(1'b0, 8'h01, 1'b1, INTC_MASK_AD, 32'h0C);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h01, 1'b0, INTC_CAUSE_AD, 32'd0);
    check("mask_restore_intr", {31'd0, INTR}, 32'd1);

    // Randomized traffic.
    rs = 8'h01;
    for (int i = 0; i < 400; i++) begin
      rs = rs ^ (8'($urandom) & 8'($urandom));
      case ($urandom_range(0, 4))
        0: ra = INTC_PEND_AD;
        1: ra = INTC_MASK_AD;
        2: ra = INTC_CAUSE_AD;
        3: ra = SSEG_AD;
        default: ra = $urandom & 32'hFFFF_FFFC;
      endcase
      cyc(($urandom_range(0, 63) == 0), rs, ($urandom_range(0, 3) == 0), ra, $urandom);
    end

    // Reset in ACTIVE.
    cyc(1'b0, 8'h00, 1'b0, INTC_PEND_AD, 32'd0);
    cyc(1'b0, 8'h00, 1'b1, INTC_MASK_AD, 32'hFF);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h10, 1'b0, INTC_CAUSE_AD, 32'd0);
    check("pre_reset_active", {31'd0, INTR}, 32'd1);
    cyc(1'b1, 8'h10, 1'b0, INTC_PEND_AD, 32'd0);
    check("rst_active_intr", {31'd0, INTR}, 32'd0);
    check("rst_active_pend", RD_DATA, 32'd0);
    check("rst_active_hit", {31'd0, HIT}, 32'd1);
    cyc(1'b0, 8'h10, 1'b0, INTC_MASK_AD, 32'd0);
    check("rst_active_mask", RD_DATA, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
